store_packer: RTL
=================

# store_packer

Downstream stage of the negator in the memory-streaming datapath. Accepts 32-bit negated integers over a valid/ready handshake and packs two consecutive integers into one 64-bit word, low half first. Issues one store per packed word to the shared memory bus with tag-based completion and an auto-incrementing address. Asserts `done` once the configured address range has been written.

## Interface
- `INTEGER_WIDTH`, 32: width of one negator result.
- `MEM_WIDTH`, 64: memory data width. Must equal 2*`INTEGER_WIDTH`.
- `BASE_ADDR`, 64'h0: address of the first store.
- `END_ADDR`, 64'h10000: exclusive end address. Must be greater than `BASE_ADDR`, and `END_ADDR`−`BASE_ADDR` must be a multiple of `ADDR_STRIDE`.
- `ADDR_STRIDE`, 64'd8: address increment per completed store.

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `neg_valid`  in  1  negator result valid.
- `neg_ready`  out  1  block accepts a result this cycle.
- `neg_data`  in  `INTEGER_WIDTH`  negator result.
- `mem2proc_response`  in  4  0 = store not accepted; nonzero = tag assigned to this cycle's request.
- `mem2proc_tag`  in  4  0 = no completion; nonzero = tag of the completing transaction.
- `proc2mem_command`  out  2  `BUS_NONE`=2'b00, `BUS_LOAD`=2'b01, `BUS_STORE`=2'b10. This block drives only NONE or STORE.
- `proc2mem_address`  out  64  store address; 0 when the command is NONE.
- `proc2mem_data`  out  `MEM_WIDTH`  {hi, lo} packed word; 0 when the command is NONE.
- `done`  out  1  sticky: the whole range has been stored.

## Operation
- FSM states: `FILL_LO`, `FILL_HI`, `ISSUE`, `WAIT`, `DONE`.
- **`FILL_LO`**
  - `neg_ready`=1.
  - On `neg_valid`, capture `neg_data` into lo and go to `FILL_HI`.
- **`FILL_HI`**
  - `neg_ready`=1.
  - On `neg_valid`, capture `neg_data` into hi and go to `ISSUE`.
- **`ISSUE`**
  - Drive `proc2mem_command`=`BUS_STORE`, `proc2mem_address`=cur_addr, `proc2mem_data`={hi,lo}.
  - If `mem2proc_response`==0: stay in `ISSUE` and hold all values. The store retries every cycle.
  - Otherwise: latch the response into pend_tag and go to `WAIT`.
- **`WAIT`**
  - Command is NONE.
  - When `mem2proc_tag`==pend_tag (nonzero): cur_addr += `ADDR_STRIDE` and clear pend_tag.
  - If the new cur_addr==`END_ADDR`, go to `DONE`; otherwise go to `FILL_LO`.
  - Nonzero tags that do not match pend_tag are ignored.
- **`DONE`**
  - `done`=1, `neg_ready`=0, command NONE.
  - Held until reset.
- Only one outstanding store at a time (no MSHR). `neg_ready`=0 in `ISSUE`, `WAIT` and `DONE`.
- Address arithmetic is 64-bit unsigned. Wrap past 2^64 cannot occur given the parameter constraints.

## Timing
- All outputs are Moore, decoded from registered state only. There is no combinational path from `neg_valid`, `mem2proc_response` or `mem2proc_tag` to any output.
- Handshake: a result transfers on a rising edge where `neg_valid`&&`neg_ready`. `neg_data` must be held by the producer while `neg_valid`=1 and `neg_ready`=0.
- Minimum cycles per word (memory accepts immediately, completion N cycles after accept): 2 fill + 1 issue + N wait.
- Completion in the cycle immediately after accept is legal (N=1).
- `mem2proc_response` is sampled only in `ISSUE`; `mem2proc_tag` is sampled only in `WAIT`.
- Reset values, effective after the first edge with `reset`=1:
  - state=`FILL_LO`, `neg_ready`=1
  - `proc2mem_command`=`BUS_NONE`, `proc2mem_address`=0, `proc2mem_data`=0
  - `done`=0
  - cur_addr=`BASE_ADDR`, pend_tag=0, lo=hi=0
- Reset mid-operation: any half-filled word and any outstanding store are abandoned. A completion tag that arrives after reset is ignored.

## Structure
- Shared package `mem_bus_pkg`: `BUS_NONE`/`BUS_LOAD`/`BUS_STORE` command constants, `MEM_TAG_WIDTH`=4, `MEM_ADDR_WIDTH`=64. The upstream datapath and the memory model use the same package.
- The FSM state enum is local to the module.
- One natural sub-module: `int_pair_packer`, holding the lo/hi capture registers and the fill-phase handshake. It exposes `word_valid` and `word` and takes `clear` from the store FSM.

## Test plan
- **Basic packing:** push 0xFFFFFFFF then 0x00000001, memory accepts with tag 3, completes with tag 3 two cycles later → one `BUS_STORE` at address 0x0 with data 0x00000001_FFFFFFFF; next store at address 0x8.
- **Backpressure:** `mem2proc_response`=0 for 5 cycles, then 7 → command stays `BUS_STORE` with constant address and data for 6 cycles, one accept; `neg_ready`=0 throughout.
- **Tag filtering:** in `WAIT` with pend_tag=5, drive tag 2 then tag 5 → tag 2 ignored; state leaves `WAIT` only on tag 5.
- **End of range:** `BASE_ADDR`=0x0, `END_ADDR`=0x18, 6 results → exactly 3 stores (0x0, 0x8, 0x10), `done`=1 after the third completion; `neg_ready` stays 0 under a further `neg_valid`.
- **Reset mid-operation:** assert `reset` in `WAIT` (pend_tag=4), then drive tag 4 after reset → no address advance, state `FILL_LO`, next store at `BASE_ADDR`.
- **Producer stall:** `neg_valid` low for 3 cycles between lo and hi → `neg_ready` held at 1; packed word is correct with no duplicate capture.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg
// Shared definitions for the memory-streaming datapath: bus command
// encodings and the address/tag widths used by every bus client and the
// memory model.
package mem_bus_pkg;

    localparam int MEM_TAG_WIDTH  = 4;
    localparam int MEM_ADDR_WIDTH = 64;

    localparam logic [1:0] BUS_NONE  = 2'b00;
    localparam logic [1:0] BUS_LOAD  = 2'b01;
    localparam logic [1:0] BUS_STORE = 2'b10;

endpackage

// File: rtl/int_pair_packer.sv
// int_pair_packer
// Collects two consecutive integers from a valid/ready stream into one
// double-width word, low half first. Once both halves are held the input
// stalls until the owner pulses clear.
//
// Ports:
//   clock, reset         clock and synchronous active-high reset
//   in_valid/in_ready    producer handshake
//   in_data              integer from the producer
//   clear                drop the held word and start a new one
//   word_valid           both halves are held
//   word                 {hi, lo}
module int_pair_packer #(
    parameter int INTEGER_WIDTH = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INTEGER_WIDTH-1:0]   in_data,
    input  logic                       clear,
    output logic                       word_valid,
    output logic [2*INTEGER_WIDTH-1:0] word
);

    logic [INTEGER_WIDTH-1:0] lo_q, lo_d;
    logic [INTEGER_WIDTH-1:0] hi_q, hi_d;
    logic                     phase_q, phase_d;   // 1: next capture is hi
    logic                     full_q, full_d;

    always_comb begin
        lo_d    = lo_q;
        hi_d    = hi_q;
        phase_d = phase_q;
        full_d  = full_q;
        if (clear) begin
            phase_d = 1'b0;
            full_d  = 1'b0;
        end else if (in_valid && !full_q) begin
            if (!phase_q) begin
                lo_d    = in_data;
                phase_d = 1'b1;
            end else begin
                hi_d    = in_data;
                phase_d = 1'b0;
                full_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lo_q    <= '0;
            hi_q    <= '0;
            phase_q <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            phase_q <= phase_d;
            full_q  <= full_d;
        end
    end

    // A held word also keeps the input closed after the last store, so the
    // owner simply never clears once the range is finished.
    assign in_ready   = !full_q;
    assign word_valid = full_q;
    assign word       = {hi_q, lo_q};

endmodule

// File: rtl/store_packer.sv
// store_packer
// Packs pairs of negator results into 64-bit words and stores each word to
// the shared memory bus at an auto-incrementing address, one outstanding
// store at a time. done latches once the address range is covered.
//
// Ports:
//   clock, reset                      clock and synchronous active-high reset
//   neg_valid/neg_ready/neg_data      negator result stream
//   mem2proc_response                 nonzero tag = store accepted this cycle
//   mem2proc_tag                      nonzero tag = transaction completing
//   proc2mem_command/address/data     bus request (zeros when idle)
//   done                              sticky range-complete flag
//
// state   | meaning
// FILL_LO | waiting for the low integer
// FILL_HI | waiting for the high integer
// ISSUE   | driving the store, retried until accepted
// WAIT    | store accepted, waiting for its completion tag
// DONE    | whole range stored, input closed until reset
module store_packer
    import mem_bus_pkg::*;
#(
    parameter int          INTEGER_WIDTH = 32,
    parameter int          MEM_WIDTH     = 64,
    parameter logic [63:0] BASE_ADDR     = 64'h0,
    parameter logic [63:0] END_ADDR      = 64'h10000,
    parameter logic [63:0] ADDR_STRIDE   = 64'd8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      neg_valid,
    output logic                      neg_ready,
    input  logic [INTEGER_WIDTH-1:0]  neg_data,
    input  logic [MEM_TAG_WIDTH-1:0]  mem2proc_response,
    input  logic [MEM_TAG_WIDTH-1:0]  mem2proc_tag,
    output logic [1:0]                proc2mem_command,
    output logic [MEM_ADDR_WIDTH-1:0] proc2mem_address,
    output logic [MEM_WIDTH-1:0]      proc2mem_data,
    output logic                      done
);

    typedef enum logic [2:0] {
        FILL_LO,
        FILL_HI,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [MEM_ADDR_WIDTH-1:0] next_addr;
    logic [MEM_TAG_WIDTH-1:0]  pend_tag_q, pend_tag_d;
    logic                      clear;
    logic                      word_valid;
    logic [MEM_WIDTH-1:0]      word;

    int_pair_packer #(
        .INTEGER_WIDTH (INTEGER_WIDTH)
    ) u_packer (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (neg_valid),
        .in_ready   (neg_ready),
        .in_data    (neg_data),
        .clear      (clear),
        .word_valid (word_valid),
        .word       (word)
    );

    assign next_addr = cur_addr_q + ADDR_STRIDE;

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        pend_tag_d = pend_tag_q;
        clear      = 1'b0;
        case (state_q)
            FILL_LO: if (neg_valid && neg_ready) state_d = FILL_HI;
            FILL_HI: if (neg_valid && neg_ready) state_d = ISSUE;
            ISSUE: begin
                if (mem2proc_response != '0) begin
                    pend_tag_d = mem2proc_response;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (mem2proc_tag != '0 && mem2proc_tag == pend_tag_q) begin
                    cur_addr_d = next_addr;
                    pend_tag_d = '0;
                    if (next_addr == END_ADDR) begin
                        state_d = DONE;
                    end else begin
                        state_d = FILL_LO;
                        clear   = 1'b1;
                    end
                end
            end
            DONE:    state_d = DONE;
            default: state_d = FILL_LO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= FILL_LO;
            cur_addr_q <= BASE_ADDR;
            pend_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            pend_tag_q <= pend_tag_d;
        end
    end

    // Outputs depend on registered state only; bus fields read zero when idle.
    assign proc2mem_command = (state_q == ISSUE) ? BUS_STORE : BUS_NONE;
    assign proc2mem_address = (state_q == ISSUE) ? cur_addr_q : '0;
    assign proc2mem_data    = (state_q == ISSUE && word_valid) ? word : '0;
    assign done             = (state_q == DONE);

endmodule
